// File: rtl/sat_spare_remap.sv
// Logical-to-physical row remapper with spare rows and a refresh-copy handshake.
// Latency: address translation is combinational; table and FIFO updates show the cycle after the edge.
// Backpressure: ref_start is ignored while a copy is in flight; a write collision aborts the copy.
module sat_spare_remap #(
  parameter  int LADDR_W = 3,
  parameter  int NSPARE  = 1,
  localparam int PADDR_W = $clog2((1 << LADDR_W) + NSPARE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LADDR_W-1:0] waddr,
  input  logic               we,
  input  logic [LADDR_W-1:0] raddr,
  input  logic               ref_start,
  input  logic [LADDR_W-1:0] ref_addr,
  input  logic               ref_done,
  output logic [PADDR_W-1:0] waddr_o,
  output logic [PADDR_W-1:0] raddr_o,
  output logic [PADDR_W-1:0] ref_src_o,
  output logic [PADDR_W-1:0] ref_dst_o,
  output logic               ref_busy,
  output logic               ref_commit,
  output logic               ref_abort
);

  localparam int NROWS = 1 << LADDR_W;

  typedef enum logic {IDLE, COPY} state_t;

  state_t             state;
  logic [PADDR_W-1:0] map     [NROWS];
  // Free list: head at index 0; holds NSPARE rows in IDLE, NSPARE-1 in COPY.
  // Popping shifts toward the head, so the tail slot NSPARE-1 is always
  // the vacant one while copying and pushes land there unconditionally.
  logic [PADDR_W-1:0] free_row[NSPARE];
  logic [LADDR_W-1:0] lat_addr;
  logic               collision;

  // Translation reads the live table; during COPY the latched row still
  // holds its old mapping, so reads of it naturally return ref_src_o.
  assign waddr_o = map[waddr];
  assign raddr_o = map[raddr];

  // A write to the row being copied invalidates the copy in flight.
  assign collision = (state == COPY) && we && (waddr == lat_addr);

  // Refresh FSM owning the map table, free list and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      ref_src_o  <= '0;
      ref_dst_o  <= '0;
      ref_busy   <= 1'b0;
      ref_commit <= 1'b0;
      ref_abort  <= 1'b0;
      for (int i = 0; i < NROWS; i++) begin
        map[i] <= PADDR_W'(i);
      end
      for (int i = 0; i < NSPARE; i++) begin
        free_row[i] <= PADDR_W'(NROWS + i);
      end
    end else begin
      ref_commit <= 1'b0;
      ref_abort  <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_start) begin
            lat_addr  <= ref_addr;
            ref_src_o <= map[ref_addr];
            ref_dst_o <= free_row[0];
            for (int i = 0; i < NSPARE - 1; i++) begin
              free_row[i] <= free_row[i+1];
            end
            ref_busy  <= 1'b1;
            state     <= COPY;
          end
        end
        COPY: begin
          if (collision) begin
            // Abort wins over a simultaneous ref_done: the spare goes back unused.
            free_row[NSPARE-1] <= ref_dst_o;
            ref_abort          <= 1'b1;
            ref_busy           <= 1'b0;
            state              <= IDLE;
          end else if (ref_done) begin
            map[lat_addr]      <= ref_dst_o;
            free_row[NSPARE-1] <= ref_src_o;
            ref_commit         <= 1'b1;
            ref_busy           <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sat_spare_remap.md
SAT_SPARE_REMAP -- requirements
Module: sat_spare_remap

Interface
REQ-001 The block SHALL have parameter LADDR_W, default 3, meaning the logical row address width (2^LADDR_W logical rows).
REQ-002 The block SHALL have parameter NSPARE, default 1, legal range 1..4, meaning the number of spare physical rows.
REQ-003 The block SHALL have derived localparam PADDR_W = clog2(2^LADDR_W + NSPARE), meaning the physical row address width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 waddr  in  LADDR_W  logical write row.
REQ-007 we  in  1  write strobe qualifying waddr for collision detection.
REQ-008 raddr  in  LADDR_W  logical read row.
REQ-009 ref_start  in  1  request to refresh-copy logical row ref_addr, sampled in IDLE only.
REQ-010 ref_addr  in  LADDR_W  logical row to refresh.
REQ-011 ref_done  in  1  copy-engine completion strobe, sampled in COPY only.
REQ-012 waddr_o / raddr_o  out  PADDR_W  translated physical write/read rows.
REQ-013 ref_src_o / ref_dst_o  out  PADDR_W  copy source / destination physical rows.
REQ-014 ref_busy  out  1  high while in COPY.
REQ-015 ref_commit / ref_abort  out  1  one-cycle pulses on successful remap / aborted refresh.

Function
REQ-016 The block SHALL hold map[0..2^LADDR_W-1] of PADDR_W entries plus a free FIFO of depth NSPARE holding unmapped physical rows.
REQ-017 waddr_o = map[waddr] and raddr_o = map[raddr] SHALL be combinational from the current table; table updates become visible the cycle after the updating edge.
REQ-018 The FSM SHALL have states IDLE and COPY.
REQ-019 IDLE with ref_start=1 SHALL go to COPY: latch ref_addr, ref_src_o <= map[ref_addr], ref_dst_o <= free-FIFO head (popped).
REQ-020 ref_done and collision inputs SHALL be ignored in IDLE; ref_start SHALL be ignored in COPY.
REQ-021 COPY with ref_done=1 and no collision SHALL: map[latched] <= ref_dst_o, push ref_src_o to FIFO tail, pulse ref_commit, go to IDLE.
REQ-022 Collision = COPY and we=1 and waddr == latched row; it SHALL push ref_dst_o to FIFO tail, leave map unchanged, pulse ref_abort, go to IDLE.
REQ-023 Collision and ref_done in the same cycle SHALL resolve as abort.
REQ-024 A write to ref_addr in the same cycle as ref_start (IDLE) SHALL NOT abort.
REQ-025 Reads of the latched row during COPY SHALL translate to the old mapping (ref_src_o).
REQ-026 The FIFO SHALL always hold exactly NSPARE entries in IDLE and NSPARE-1 in COPY; no overflow/underflow is possible and none SHALL be flagged.
REQ-027 ref_src_o/ref_dst_o SHALL hold their values after leaving COPY until the next ref_start.

Reset
REQ-028 On rst: map[i] = i, FIFO = 2^LADDR_W .. 2^LADDR_W+NSPARE-1 in ascending order (head first), state IDLE, ref_busy/ref_commit/ref_abort = 0, ref_src_o/ref_dst_o = 0.
REQ-029 rst asserted mid-COPY SHALL discard the refresh with no ref_commit/ref_abort pulse.

Verification (LADDR_W=3, NSPARE=1, PADDR_W=4 unless noted)
REQ-030 After reset, waddr=3, raddr=4 -> waddr_o=3, raddr_o=4, ref_busy=0.
REQ-031 ref_start, ref_addr=5 -> next cycle ref_busy=1, src=5, dst=8; raddr=5 -> 5; ref_done -> ref_commit pulse, then raddr=5 -> 8.
REQ-032 Then ref_start, ref_addr=2 -> dst=5; ref_done -> raddr=2 -> 5, raddr=5 -> 8, FIFO = {2}.
REQ-033 ref_start, ref_addr=1, then we=1, waddr=1 in COPY -> ref_abort pulse, no commit, raddr=1 -> 1; next refresh reuses the same dst.
REQ-034 Collision and ref_done in the same cycle -> ref_abort only, map unchanged; rst mid-COPY -> identity map, ref_busy=0.
REQ-035 NSPARE=2: refresh rows 0 then 1 -> dst 8 then 9; after both commits, FIFO order = {0,1}.
